// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with architectural HI/LO registers.
// Works on operand magnitudes and applies sign correction in a final fixup cycle.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e            state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;

  logic                 op_signed;
  logic                 op_div;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_diff;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    sign_a    = op_signed & src_a[WIDTH-1];
    sign_b    = op_signed & src_b[WIDTH-1];
    abs_a     = sign_a ? (~src_a + 1'b1) : src_a;
    abs_b     = sign_b ? (~src_b + 1'b1) : src_b;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  // The divide keeps the shifted remainder at WIDTH+1 bits so divisors with the
  // top bit set still compare correctly.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        acc_step = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo    = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem    = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    fix_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div_q ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            is_div_q <= op_div;
            busy     <= 1'b1;
            if (op_div && (src_b == '0)) begin
              // Preload the fixup result directly: quotient all-ones, remainder = dividend.
              acc_q     <= {src_a, {WIDTH{1'b1}}};
              opnd_q    <= '0;
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= MD_FIXUP;
            end else begin
              acc_q     <= {{WIDTH{1'b0}}, abs_a};
              opnd_q    <= abs_b;
              neg_res_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              cnt_q     <= CNT_W'(WIDTH);
              state_q   <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            state_q <= MD_IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= MD_FIXUP;
          end
        end
        MD_FIXUP: begin
          busy    <= 1'b0;
          state_q <= MD_IDLE;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

endmodule
